wb_interconnect_nxm: RTL and testbench



---
 rtl/wb_interconnect_nxm.sv | 220 ++++++++++++++++++++++
 tb/tb_wb_interconnect_nxm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_interconnect_nxm.sv
// N-master x M-slave Wishbone crossbar: address decode, per-slave round-robin ownership, watchdog.
// Latency: first beat reaches the slave 2 cycles after cyc&stb; later beats and all responses pass through combinationally.
// Backpressure: a master waits in REQ until its target is free; the grant is held while the owner keeps m_cyc high.
module wb_interconnect_nxm #(
    parameter int N_MASTERS      = 4,
    parameter int N_SLAVES       = 2,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_BASE  = '0,
    parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_LIMIT = '0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]    m_adr,
    input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]    m_dat_w,
    input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_sel,
    input  logic [N_MASTERS*3-1:0]                m_cti,
    input  logic [N_MASTERS*2-1:0]                m_bte,
    input  logic [N_MASTERS-1:0]                  m_cyc,
    input  logic [N_MASTERS-1:0]                  m_stb,
    input  logic [N_MASTERS-1:0]                  m_we,
    output logic [N_MASTERS*WB_DATA_WIDTH-1:0]    m_dat_r,
    output logic [N_MASTERS-1:0]                  m_ack,
    output logic [N_MASTERS-1:0]                  m_err,
    output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]     s_adr,
    output logic [N_SLAVES*WB_DATA_WIDTH-1:0]     s_dat_w,
    output logic [N_SLAVES*(WB_DATA_WIDTH/8)-1:0] s_sel,
    output logic [N_SLAVES*3-1:0]                 s_cti,
    output logic [N_SLAVES*2-1:0]                 s_bte,
    output logic [N_SLAVES-1:0]                   s_cyc,
    output logic [N_SLAVES-1:0]                   s_stb,
    output logic [N_SLAVES-1:0]                   s_we,
    input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]     s_dat_r,
    input  logic [N_SLAVES-1:0]                   s_ack,
    input  logic [N_SLAVES-1:0]                   s_err,
    output logic [15:0]                           decode_err_cnt,
    output logic [15:0]                           timeout_cnt
);
    localparam int AW  = WB_ADDR_WIDTH;
    localparam int DW  = WB_DATA_WIDTH;
    localparam int SW  = WB_DATA_WIDTH / 8;
    localparam int MIW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SIW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [31:0] TO_LAST = 32'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_OWN, ST_MISS, ST_WAIT} mst_t;

    mst_t           st_q [N_MASTERS];
    mst_t           st_d [N_MASTERS];
    logic [SIW-1:0] tgt_q [N_MASTERS];
    logic [SIW-1:0] tgt_d [N_MASTERS];
    logic [N_MASTERS-1:0] hit;
    logic [SIW-1:0] hit_idx [N_MASTERS];

    logic [N_SLAVES-1:0] gnt_vld_q, gnt_vld_d, gnt_chg;
    logic [MIW-1:0] gnt_idx_q [N_SLAVES];
    logic [MIW-1:0] gnt_idx_d [N_SLAVES];
    logic [MIW-1:0] last_q [N_SLAVES];
    logic [MIW-1:0] last_d [N_SLAVES];

    logic [31:0]         wd_cnt_q [N_SLAVES];
    logic [N_SLAVES-1:0] trip_q, to_pls_q, stall, trip_now;
    logic [15:0]         dec_cnt_q, to_cnt_q;
    logic [16:0]         dec_sum, to_sum;
    int                  n_miss, n_to, arb_c, so, mt;

    // Lowest-index match wins, so scan downward and let later hits overwrite.
    always_comb begin
        for (int m = 0; m < N_MASTERS; m++) begin
            hit[m]     = 1'b0;
            hit_idx[m] = '0;
            for (int s = N_SLAVES - 1; s >= 0; s--) begin
                if (m_adr[m*AW +: AW] >= SLAVE_ADDR_BASE[s*AW +: AW] &&
                    m_adr[m*AW +: AW] <= SLAVE_ADDR_LIMIT[s*AW +: AW]) begin
                    hit[m]     = 1'b1;
                    hit_idx[m] = SIW'(s);
                end
            end
        end
    end

    always_comb begin
        gnt_vld_d = gnt_vld_q;
        arb_c     = 0;
        n_miss    = 0;
        for (int s = 0; s < N_SLAVES; s++) begin
            gnt_idx_d[s] = gnt_idx_q[s];
            last_d[s]    = last_q[s];
        end
        // A slave is free when unowned or when its owner drops m_cyc; handover happens on that same edge.
        for (int s = 0; s < N_SLAVES; s++) begin
            if (!gnt_vld_q[s] || !m_cyc[gnt_idx_q[s]]) begin
                gnt_vld_d[s] = 1'b0;
                for (int k = 0; k < N_MASTERS; k++) begin
                    arb_c = int'(last_q[s]) + 1 + k;
                    if (arb_c >= N_MASTERS) arb_c = arb_c - N_MASTERS;
                    if (!gnt_vld_d[s] && st_q[arb_c] == ST_REQ && m_cyc[arb_c] &&
                        tgt_q[arb_c] == SIW'(s)) begin
                        gnt_vld_d[s] = 1'b1;
                        gnt_idx_d[s] = MIW'(arb_c);
                        last_d[s]    = MIW'(arb_c);
                    end
                end
            end
        end
        for (int m = 0; m < N_MASTERS; m++) begin
            st_d[m]  = st_q[m];
            tgt_d[m] = tgt_q[m];
            case (st_q[m])
                ST_IDLE: if (m_cyc[m] && m_stb[m]) begin
                    if (hit[m]) begin
                        st_d[m]  = ST_REQ;
                        tgt_d[m] = hit_idx[m];
                    end else begin
                        st_d[m] = ST_MISS;
                        n_miss  = n_miss + 1;
                    end
                end
                ST_REQ: if (!m_cyc[m]) st_d[m] = ST_IDLE;
                        else if (gnt_vld_d[tgt_q[m]] && gnt_idx_d[tgt_q[m]] == MIW'(m)) st_d[m] = ST_OWN;
                ST_OWN:  if (!m_cyc[m]) st_d[m] = ST_IDLE;
                ST_MISS: st_d[m] = m_cyc[m] ? ST_WAIT : ST_IDLE;
                ST_WAIT: if (!m_cyc[m]) st_d[m] = ST_IDLE;
                default: st_d[m] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        m_dat_r = '0; m_ack = '0; m_err = '0;
        s_adr = '0; s_dat_w = '0; s_sel = '0; s_cti = '0; s_bte = '0;
        s_cyc = '0; s_stb = '0; s_we = '0;
        so = 0;
        mt = 0;
        if (!rst) begin
            for (int s = 0; s < N_SLAVES; s++) begin
                if (gnt_vld_q[s]) begin
                    so = int'(gnt_idx_q[s]);
                    s_adr[s*AW +: AW]   = m_adr[so*AW +: AW];
                    s_dat_w[s*DW +: DW] = m_dat_w[so*DW +: DW];
                    s_sel[s*SW +: SW]   = m_sel[so*SW +: SW];
                    s_cti[s*3 +: 3]     = m_cti[so*3 +: 3];
                    s_bte[s*2 +: 2]     = m_bte[so*2 +: 2];
                    s_cyc[s]            = m_cyc[so] && !trip_q[s];
                    s_stb[s]            = m_stb[so] && !trip_q[s];
                    s_we[s]             = m_we[so];
                end
            end
            for (int m = 0; m < N_MASTERS; m++) begin
                if (st_q[m] == ST_OWN) begin
                    mt = int'(tgt_q[m]);
                    m_dat_r[m*DW +: DW] = s_dat_r[mt*DW +: DW];
                    m_ack[m] = s_ack[mt] && !s_err[mt] && !trip_q[mt];
                    m_err[m] = (s_err[mt] && !trip_q[mt]) || to_pls_q[mt];
                end else if (st_q[m] == ST_MISS) begin
                    m_err[m] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        n_to = 0;
        for (int s = 0; s < N_SLAVES; s++) begin
            gnt_chg[s]  = (gnt_vld_d[s] != gnt_vld_q[s]) || (gnt_idx_d[s] != gnt_idx_q[s]);
            stall[s]    = s_stb[s] && !s_ack[s] && !s_err[s];
            trip_now[s] = (TIMEOUT_CYCLES > 0) && !gnt_chg[s] && stall[s] && wd_cnt_q[s] == TO_LAST;
            if (trip_now[s]) n_to = n_to + 1;
        end
        dec_sum = {1'b0, dec_cnt_q} + 17'(n_miss);
        to_sum  = {1'b0, to_cnt_q} + 17'(n_to);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < N_MASTERS; m++) begin
                st_q[m]  <= ST_IDLE;
                tgt_q[m] <= '0;
            end
            for (int s = 0; s < N_SLAVES; s++) begin
                gnt_idx_q[s] <= '0;
                last_q[s]    <= MIW'(N_MASTERS - 1);
                wd_cnt_q[s]  <= '0;
            end
            gnt_vld_q <= '0;
            trip_q    <= '0;
            to_pls_q  <= '0;
            dec_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            for (int m = 0; m < N_MASTERS; m++) begin
                st_q[m]  <= st_d[m];
                tgt_q[m] <= tgt_d[m];
            end
            for (int s = 0; s < N_SLAVES; s++) begin
                gnt_idx_q[s] <= gnt_idx_d[s];
                last_q[s]    <= last_d[s];
                to_pls_q[s]  <= trip_now[s];
                if (gnt_chg[s]) begin
                    wd_cnt_q[s] <= '0;
                    trip_q[s]   <= 1'b0;
                end else if (trip_now[s]) begin
                    wd_cnt_q[s] <= '0;
                    trip_q[s]   <= 1'b1;
                end else if (TIMEOUT_CYCLES > 0 && stall[s]) begin
                    wd_cnt_q[s] <= wd_cnt_q[s] + 32'd1;
                end else if (s_ack[s] || s_err[s]) begin
                    wd_cnt_q[s] <= '0;
                end
            end
            gnt_vld_q <= gnt_vld_d;
            dec_cnt_q <= dec_sum[16] ? 16'hFFFF : dec_sum[15:0];
            to_cnt_q  <= to_sum[16] ? 16'hFFFF : to_sum[15:0];
        end
    end

    assign decode_err_cnt = dec_cnt_q;
    assign timeout_cnt    = to_cnt_q;
endmodule

// File: tb/tb_wb_interconnect_nxm.sv
// Directed bench for wb_interconnect_nxm: 4 masters, 2 slaves (0x0000-0x0FFF, 0x1000-0x1FFF), 8-cycle watchdog.
module tb_wb_interconnect_nxm;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] m_adr, m_dat_w, m_dat_r;
    logic [15:0]  m_sel;
    logic [11:0]  m_cti;
    logic [7:0]   m_bte;
    logic [3:0]   m_cyc, m_stb, m_we, m_ack, m_err;
    logic [63:0]  s_adr, s_dat_w, s_dat_r;
    logic [7:0]   s_sel;
    logic [5:0]   s_cti;
    logic [3:0]   s_bte;
    logic [1:0]   s_cyc, s_stb, s_we, s_ack, s_err;
    logic [15:0]  decode_err_cnt, timeout_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    int          ord_q[$];

    wb_interconnect_nxm #(
        .N_MASTERS(4), .N_SLAVES(2), .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32),
        .SLAVE_ADDR_BASE({32'h0000_1000, 32'h0000_0000}),
        .SLAVE_ADDR_LIMIT({32'h0000_1FFF, 32'h0000_0FFF}),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .decode_err_cnt(decode_err_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench stopped");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mreq(input int m, input logic [31:0] a, input logic [2:0] cti);
        m_adr[m*32 +: 32]   = a;
        m_dat_w[m*32 +: 32] = a ^ 32'hA5A5_0000;
        m_sel[m*4 +: 4]     = 4'hF;
        m_cti[m*3 +: 3]     = cti;
        m_we[m]  = 1'b0;
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
    endtask

    task automatic mdrop(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    task automatic sresp(input int s, input logic ack, input logic err, input logic [31:0] d);
        s_ack[s] = ack;
        s_err[s] = err;
        s_dat_r[s*32 +: 32] = d;
    endtask

    // Expected read data is queued when the slave drives it and retired when the master sees m_ack.
    task automatic ack_check(input int s, input int m, input logic [31:0] d);
        logic [31:0] e;
        exp_q.push_back(d);
        sresp(s, 1'b1, 1'b0, d);
        #1;
        chk("m_ack_on_slave_ack", 32'(m_ack[m]), 32'd1);
        e = exp_q.pop_front();
        if (m_ack[m]) chk("m_dat_r", m_dat_r[m*32 +: 32], e);
    endtask

    task automatic wait_grant(input int s, output int idle);
        idle = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (s_cyc[s]) break;
            idle++;
        end
        if (!s_cyc[s]) chk("grant_wait_expired", 32'(s_cyc[s]), 32'd1);
    endtask

    initial begin
        int idle;
        int owner;
        int expm;
        m_adr = '0; m_dat_w = '0; m_sel = '0; m_cti = '0; m_bte = '0;
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_dat_r = '0; s_ack = '0; s_err = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_m_ack_err", 32'({m_ack, m_err}), 32'd0);
        chk("rst_m_dat_r", m_dat_r[31:0], 32'd0);
        chk("rst_counters", {decode_err_cnt, timeout_cnt}, 32'd0);
        rst = 1'b0;

        // Single read from master 0 to slave 0
        @(negedge clk);
        mreq(0, 32'h0000_0010, 3'b000);
        @(negedge clk); #1;
        chk("lat_cycle1_s_cyc0", 32'(s_cyc[0]), 32'd0);
        @(negedge clk); #1;
        chk("lat_cycle2_s_cyc0", 32'(s_cyc[0]), 32'd1);
        chk("lat_cycle2_s_stb0", 32'(s_stb[0]), 32'd1);
        chk("fwd_s_adr0", s_adr[31:0], 32'h0000_0010);
        chk("fwd_s_dat_w0", s_dat_w[31:0], 32'hA5A5_0010);
        chk("fwd_s_sel_we_cti_bte", {20'd0, s_sel[3:0], s_we[0], s_cti[2:0], s_bte[1:0], 2'b00}, {20'd0, 4'hF, 1'b0, 3'b000, 2'b00, 2'b00});
        chk("idle_s_cyc1", 32'(s_cyc[1]), 32'd0);
        ack_check(0, 0, 32'hDEAD_BEEF);
        @(negedge clk);
        sresp(0, 1'b0, 1'b0, 32'd0);
        mdrop(0);
        #1;
        chk("drop_s_cyc0", 32'(s_cyc[0]), 32'd0);

        // Four masters contend for slave 1, two rounds
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                mreq(m, 32'h0000_1000 + 32'(16 * m), 3'b000);
                ord_q.push_back(m);
            end
            for (int g = 0; g < 4; g++) begin
                wait_grant(1, idle);
                owner = int'((s_adr[63:32] - 32'h0000_1000) >> 4) & 3;
                expm  = ord_q.pop_front();
                chk("rr_grant_order", 32'(owner), 32'(expm));
                chk("rr_idle_cycles", 32'(idle), (g == 0) ? 32'd1 : 32'd0);
                ack_check(1, owner, 32'hC0DE_0000 + 32'(r * 16 + g));
                @(negedge clk);
                sresp(1, 1'b0, 1'b0, 32'd0);
                mdrop(owner);
            end
        end

        // Unmapped address from master 2
        @(negedge clk);
        mreq(2, 32'h0000_8000, 3'b000);
        @(negedge clk); #1;
        chk("miss_m_err2", 32'(m_err[2]), 32'd1);
        chk("miss_no_s_cyc", 32'(s_cyc), 32'd0);
        chk("miss_no_m_ack", 32'(m_ack), 32'd0);
        @(negedge clk); #1;
        chk("miss_err_one_cycle", 32'(m_err[2]), 32'd0);
        chk("miss_decode_err_cnt", 32'(decode_err_cnt), 32'd1);
        chk("miss_still_no_s_cyc", 32'(s_cyc), 32'd0);
        mdrop(2);

        // Slave 0 never answers: watchdog fires after 8 stalled cycles
        @(negedge clk);
        mreq(0, 32'h0000_0020, 3'b000);
        wait_grant(0, idle);
        for (int i = 0; i < 8; i++) begin
            chk("wd_stall_s_stb0", 32'(s_stb[0]), 32'd1);
            chk("wd_stall_no_err", 32'(m_err[0]), 32'd0);
            @(negedge clk); #1;
        end
        chk("wd_m_err0", 32'(m_err[0]), 32'd1);
        chk("wd_s_stb0_forced", 32'(s_stb[0]), 32'd0);
        chk("wd_s_cyc0_forced", 32'(s_cyc[0]), 32'd0);
        @(negedge clk); #1;
        chk("wd_err_one_cycle", 32'(m_err[0]), 32'd0);
        chk("wd_s_stb0_held_low", 32'(s_stb[0]), 32'd0);
        chk("wd_timeout_cnt", 32'(timeout_cnt), 32'd1);
        mdrop(0);

        // 4-beat burst from master 1 while master 0 waits on slave 0
        @(negedge clk);
        mreq(1, 32'h0000_0030, 3'b010);
        @(negedge clk);
        mreq(0, 32'h0000_0040, 3'b000);
        wait_grant(0, idle);
        for (int b = 0; b < 4; b++) begin
            chk("burst_s_adr0", s_adr[31:0], 32'h0000_0030 + 32'(4 * b));
            chk("burst_s_cti0", 32'(s_cti[2:0]), 32'd2);
            if (b < 3) begin
                ack_check(0, 1, 32'hB000_0000 + 32'(b));
            end else begin
                sresp(0, 1'b1, 1'b1, 32'h0000_0055);
                #1;
                chk("ack_err_m_err1", 32'(m_err[1]), 32'd1);
                chk("ack_err_m_ack1", 32'(m_ack[1]), 32'd0);
            end
            chk("burst_waiter_no_ack", 32'({m_ack[0], m_err[0]}), 32'd0);
            @(negedge clk);
            sresp(0, 1'b0, 1'b0, 32'd0);
            if (b < 3) m_adr[63:32] = 32'h0000_0030 + 32'(4 * (b + 1));
            else       mdrop(1);
            #1;
        end
        chk("burst_release_s_cyc0", 32'(s_cyc[0]), 32'd0);
        @(negedge clk); #1;
        chk("handover_s_cyc0", 32'(s_cyc[0]), 32'd1);
        chk("handover_s_adr0", s_adr[31:0], 32'h0000_0040);
        ack_check(0, 0, 32'h0000_4040);
        @(negedge clk);
        sresp(0, 1'b0, 1'b0, 32'd0);
        mdrop(0);

        // Reset in the middle of an owned transfer
        @(negedge clk);
        mreq(3, 32'h0000_1030, 3'b000);
        wait_grant(1, idle);
        chk("prerst_s_cyc1", 32'(s_cyc[1]), 32'd1);
        rst = 1'b1;
        mdrop(3);
        sresp(1, 1'b1, 1'b0, 32'h0000_1234);
        @(negedge clk); #1;
        chk("inrst_s_outputs", 32'({s_cyc, s_stb, s_we}), 32'd0);
        chk("inrst_m_ack_err", 32'({m_ack, m_err}), 32'd0);
        chk("inrst_m_dat_r3", m_dat_r[127:96], 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("postrst_no_m_ack", 32'({m_ack, m_err}), 32'd0);
            chk("postrst_no_s_cyc", 32'(s_cyc), 32'd0);
        end
        chk("postrst_counters", {decode_err_cnt, timeout_cnt}, 32'd0);
        sresp(1, 1'b0, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
